// File: rtl/spi_master.sv
// SPI mode-0 master: byte stream in, serial frames out; tx_last ends a chip-select frame.
// Latency: first sck rise CS_SETUP+HALF_PERIOD clks after accept; rx_valid follows the 8th rise.
// Backpressure: one-entry holding buffer; tx_ready drops when it is full or once a last byte is taken.
module spi_master #(
  parameter int HALF_PERIOD = 4,
  parameter int CS_SETUP    = 2,
  parameter int CS_HOLD     = 2,
  parameter int CS_IDLE     = 2
) (
  input  logic       clk,
  input  logic       rst_n,
  output logic       sck,
  output logic       mosi,
  input  logic       miso,
  output logic       n_cs,
  input  logic [7:0] tx_data,
  input  logic       tx_valid,
  input  logic       tx_last,
  output logic       tx_ready,
  output logic [7:0] rx_data,
  output logic       rx_valid,
  output logic       busy
);

  typedef enum logic [2:0] {
    S_IDLE,
    S_SETUP,
    S_LOW,
    S_HIGH,
    S_HOLD,
    S_GAP
  } state_t;

  // Terminal counts for the shared 8-bit phase counter.
  localparam logic [7:0] HP_END    = 8'(HALF_PERIOD - 1);
  localparam logic [7:0] SETUP_END = 8'(CS_SETUP - 1);
  localparam logic [7:0] HOLD_END  = 8'(CS_HOLD - 1);
  localparam logic [7:0] IDLE_END  = 8'(CS_IDLE - 1);

  state_t      r_state;
  logic [7:0]  r_cnt;
  logic [2:0]  r_bit;
  logic [7:0]  r_shift_tx;
  logic [7:0]  r_shift_rx;
  logic        r_cur_last;   // byte on the wire closes the frame
  logic [7:0]  r_buf_dat;
  logic        r_buf_vld;
  logic        r_buf_last;
  logic        r_last_seen;  // some accepted byte of this frame carried tx_last
  logic        r_wait;       // byte boundary reached with nothing queued; sck parked low
  logic        r_sck;
  logic        r_mosi;
  logic        r_n_cs;
  logic        r_tx_ready;
  logic [7:0]  r_rx_data;
  logic        r_rx_valid;
  logic        r_busy;

  logic        w_accept;
  logic        w_hp_done;
  logic [7:0]  w_rx_next;

  assign w_accept  = tx_valid && r_tx_ready;
  assign w_hp_done = (r_cnt == HP_END);
  assign w_rx_next = {r_shift_rx[6:0], miso};

  assign sck      = r_sck;
  assign mosi     = r_mosi;
  assign n_cs     = r_n_cs;
  assign tx_ready = r_tx_ready;
  assign rx_data  = r_rx_data;
  assign rx_valid = r_rx_valid;
  assign busy     = r_busy;

  // Frame sequencer: chip-select timing, sck generation, shifting and the holding buffer.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_state     <= S_IDLE;
      r_cnt       <= 8'd0;
      r_bit       <= 3'd0;
      r_shift_tx  <= 8'd0;
      r_shift_rx  <= 8'd0;
      r_cur_last  <= 1'b0;
      r_buf_dat   <= 8'd0;
      r_buf_vld   <= 1'b0;
      r_buf_last  <= 1'b0;
      r_last_seen <= 1'b0;
      r_wait      <= 1'b0;
      r_sck       <= 1'b0;
      r_mosi      <= 1'b0;
      r_n_cs      <= 1'b1;
      r_tx_ready  <= 1'b0;
      r_rx_data   <= 8'd0;
      r_rx_valid  <= 1'b0;
      r_busy      <= 1'b0;
    end else begin
      r_rx_valid <= 1'b0;

      // Outside IDLE an accepted byte lands in the holding buffer; branches that
      // put it straight onto the wire override the buffer flags below.
      if (w_accept && (r_state != S_IDLE)) begin
        r_buf_dat   <= tx_data;
        r_buf_last  <= tx_last;
        r_buf_vld   <= 1'b1;
        r_tx_ready  <= 1'b0;
        r_last_seen <= r_last_seen | tx_last;
      end

      case (r_state)
        S_IDLE: begin
          r_tx_ready <= 1'b1;
          r_busy     <= 1'b0;
          if (w_accept) begin
            r_state     <= S_SETUP;
            r_n_cs      <= 1'b0;
            r_mosi      <= tx_data[7];
            r_shift_tx  <= tx_data;
            r_cur_last  <= tx_last;
            r_last_seen <= tx_last;
            r_tx_ready  <= !tx_last;
            r_busy      <= 1'b1;
            r_cnt       <= 8'd0;
            r_bit       <= 3'd0;
            r_wait      <= 1'b0;
          end
        end

        S_SETUP: begin
          if (r_cnt == SETUP_END) begin
            r_state <= S_LOW;
            r_cnt   <= 8'd0;
          end else begin
            r_cnt <= r_cnt + 8'd1;
          end
        end

        S_LOW: begin
          if (r_wait) begin
            // Late byte: load directly, then time a full low phase from the next cycle.
            if (w_accept) begin
              r_shift_tx  <= tx_data;
              r_mosi      <= tx_data[7];
              r_cur_last  <= tx_last;
              r_last_seen <= tx_last;
              r_buf_vld   <= 1'b0;
              r_tx_ready  <= !tx_last;
              r_wait      <= 1'b0;
              r_cnt       <= 8'd0;
            end
          end else if (w_hp_done) begin
            r_sck      <= 1'b1;
            r_state    <= S_HIGH;
            r_cnt      <= 8'd0;
            r_shift_rx <= w_rx_next;
            if (r_bit == 3'd7) begin
              r_rx_data  <= w_rx_next;
              r_rx_valid <= 1'b1;
            end
          end else begin
            r_cnt <= r_cnt + 8'd1;
          end
        end

        S_HIGH: begin
          if (w_hp_done) begin
            r_sck   <= 1'b0;
            r_cnt   <= 8'd0;
            r_bit   <= r_bit + 3'd1;
            r_state <= S_LOW;
            if (r_bit != 3'd7) begin
              r_mosi     <= r_shift_tx[6];
              r_shift_tx <= {r_shift_tx[6:0], 1'b0};
            end else if (r_cur_last) begin
              r_state <= S_HOLD;
            end else if (r_buf_vld) begin
              r_shift_tx <= r_buf_dat;
              r_mosi     <= r_buf_dat[7];
              r_cur_last <= r_buf_last;
              r_buf_vld  <= 1'b0;
              r_tx_ready <= !r_last_seen;
            end else if (w_accept) begin
              // Byte arriving exactly at the boundary goes straight onto the wire.
              r_shift_tx  <= tx_data;
              r_mosi      <= tx_data[7];
              r_cur_last  <= tx_last;
              r_last_seen <= tx_last;
              r_buf_vld   <= 1'b0;
              r_tx_ready  <= !tx_last;
            end else begin
              r_wait <= 1'b1;
            end
          end else begin
            r_cnt <= r_cnt + 8'd1;
          end
        end

        S_HOLD: begin
          r_tx_ready <= 1'b0;
          if (r_cnt == HOLD_END) begin
            r_n_cs  <= 1'b1;
            r_state <= S_GAP;
            r_cnt   <= 8'd0;
          end else begin
            r_cnt <= r_cnt + 8'd1;
          end
        end

        S_GAP: begin
          r_tx_ready <= 1'b0;
          if (r_cnt == IDLE_END) begin
            r_state     <= S_IDLE;
            r_tx_ready  <= 1'b1;
            r_last_seen <= 1'b0;
            r_busy      <= 1'b0;
            r_cnt       <= 8'd0;
          end else begin
            r_cnt <= r_cnt + 8'd1;
          end
        end

        default: begin
          r_state <= S_IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_spi_master.sv
// Directed bench for spi_master: framing, buffering, stall/resume, reset, chip-select gap.
// Miso comes from a loopback of mosi, a constant 1, or a small mode-0 peripheral model.
// Expected values are hand-computed for HALF_PERIOD=2, CS_SETUP=2, CS_HOLD=2, CS_IDLE=3.
module tb_spi_master;
  localparam int HP  = 2;
  localparam int CSS = 2;
  localparam int CSH = 2;
  localparam int CSI = 3;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic       rst_n, sck, mosi, miso, n_cs, tx_valid, tx_last, tx_ready, rx_valid, busy;
  logic [7:0] tx_data, rx_data;

  int total = 0;
  int bad   = 0;

  int          miso_mode  = 0;
  logic [15:0] slave_load = 16'h0000;
  logic [15:0] slave_sh   = 16'h0000;
  logic [15:0] slave_rx   = 16'h0000;

  logic sck_q   = 1'b0;
  logic n_cs_q  = 1'b1;
  int   cyc      = 0;
  int   n_rise   = 0;
  int   n_rxv    = 0;
  int   n_csr    = 0;
  int   run      = 1000;
  int   n_glitch = 0;
  logic       mosi_q[$];
  logic [7:0] rx_q[$];
  int         rise_t[$];

  assign miso = (miso_mode == 0) ? mosi : (miso_mode == 1) ? 1'b1 : slave_sh[15];

  spi_master #(
    .HALF_PERIOD(HP),
    .CS_SETUP   (CSS),
    .CS_HOLD    (CSH),
    .CS_IDLE    (CSI)
  ) dut (
    .clk     (clk),
    .rst_n   (rst_n),
    .sck     (sck),
    .mosi    (mosi),
    .miso    (miso),
    .n_cs    (n_cs),
    .tx_data (tx_data),
    .tx_valid(tx_valid),
    .tx_last (tx_last),
    .tx_ready(tx_ready),
    .rx_data (rx_data),
    .rx_valid(rx_valid),
    .busy    (busy)
  );

  // Bus monitor: sck edges, mosi bits at rise, rx strobes, chip-select rises, sck level lengths.
  always @(posedge clk) begin
    cyc    <= cyc + 1;
    sck_q  <= sck;
    n_cs_q <= n_cs;
    if (sck && !sck_q) begin
      n_rise <= n_rise + 1;
      mosi_q.push_back(mosi);
      rise_t.push_back(cyc);
    end
    if (rx_valid) begin
      n_rxv <= n_rxv + 1;
      rx_q.push_back(rx_data);
    end
    if (n_cs && !n_cs_q) n_csr <= n_csr + 1;
    if (n_cs) run <= 1000;
    else if (sck != sck_q) begin
      if (run < HP) n_glitch <= n_glitch + 1;
      run <= 1;
    end else run <= run + 1;
  end

  // Mode-0 peripheral: shifts out on sck fall, captures mosi on sck rise.
  always @(posedge clk) begin
    if (n_cs) slave_sh <= slave_load;
    else if (!sck && sck_q) slave_sh <= {slave_sh[14:0], 1'b0};
    if (!n_cs && sck && !sck_q) slave_rx <= {slave_rx[14:0], mosi};
  end

  task automatic tick(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic push(input string tag, input logic [7:0] d, input logic l);
    logic acc;
    int   n;
    tx_data  = d;
    tx_last  = l;
    tx_valid = 1'b1;
    acc = 1'b0;
    n   = 0;
    while (!acc && n < 300) begin
      acc = tx_ready;
      tick(1);
      n++;
    end
    tx_valid = 1'b0;
    chk(tag, {31'b0, acc}, 32'd1);
  endtask

  task automatic wait_idle(input string tag);
    int n;
    n = 0;
    while (busy && n < 400) begin
      tick(1);
      n++;
    end
    chk(tag, {31'b0, busy}, 32'd0);
  endtask

  task automatic wait_rises(input string tag, input int target);
    int n;
    n = 0;
    while (n_rise < target && n < 400) begin
      tick(1);
      n++;
    end
    chk(tag, n_rise, target);
  endtask

  task automatic cycles_to_rise(input string tag, input int exp);
    int k;
    k = 0;
    while (!sck && k < 60) begin
      tick(1);
      k++;
    end
    chk(tag, k, exp);
  endtask

  function automatic logic [7:0] mosi_byte(input int s);
    logic [7:0] b;
    b = 8'h00;
    for (int i = 0; i < 8; i++) b = {b[6:0], (s + i < mosi_q.size()) ? mosi_q[s + i] : 1'b0};
    return b;
  endfunction

  function automatic int span(input int s, input int n);
    if (s + n < rise_t.size()) return rise_t[s + n] - rise_t[s];
    return -1;
  endfunction

  function automatic logic [7:0] rx_at(input int i);
    if (i < rx_q.size()) return rx_q[i];
    return 8'bx;
  endfunction

  int r0, v0, m0, t0, q0, c0, hi, viol;
  logic acc;
  int n;

  initial begin
    rst_n = 1'b0; tx_valid = 1'b0; tx_data = 8'h00; tx_last = 1'b0;
    tick(3);
    chk("rst_outputs", {26'b0, n_cs, sck, mosi, tx_ready, rx_valid, busy}, 32'b100000);
    chk("rst_rx_data", rx_data, 32'h00);
    rst_n = 1'b1;
    tick(1);
    chk("ready_after_rst", tx_ready, 1);

    // Single last byte, loopback
    miso_mode = 0;
    r0 = n_rise; v0 = n_rxv; m0 = mosi_q.size(); t0 = rise_t.size(); q0 = rx_q.size();
    push("A_accept", 8'hA5, 1'b1);
    chk("A_ncs_fall", n_cs, 0);
    chk("A_mosi_msb", mosi, 1);
    chk("A_ready_after_last", tx_ready, 0);
    chk("A_busy", busy, 1);
    cycles_to_rise("A_first_rise", 4);
    wait_idle("A_idle");
    chk("A_rises", n_rise - r0, 8);
    chk("A_mosi_bits", mosi_byte(m0), 8'hA5);
    chk("A_period", span(t0, 7), 28);
    chk("A_rxv_count", n_rxv - v0, 1);
    chk("A_rx_data", rx_at(q0), 8'hA5);

    // Two bytes back-to-back via the holding buffer, miso tied high
    miso_mode = 1;
    r0 = n_rise; v0 = n_rxv; m0 = mosi_q.size(); t0 = rise_t.size(); q0 = rx_q.size(); c0 = n_csr;
    push("B_accept0", 8'h3C, 1'b0);
    chk("B_ready_empty_buf", tx_ready, 1);
    push("B_accept1", 8'hC3, 1'b1);
    chk("B_ready_full_buf", tx_ready, 0);
    wait_idle("B_idle");
    chk("B_rises", n_rise - r0, 16);
    chk("B_contiguous", span(t0, 15), 60);
    chk("B_ncs_rises", n_csr - c0, 1);
    chk("B_rxv_count", n_rxv - v0, 2);
    chk("B_rx0", rx_at(q0), 8'hFF);
    chk("B_rx1", rx_at(q0 + 1), 8'hFF);
    chk("B_mosi0", mosi_byte(m0), 8'h3C);
    chk("B_mosi1", mosi_byte(m0 + 8), 8'hC3);

    // Second byte arrives 20 cycles late: sck parks low with chip select held
    miso_mode = 0;
    r0 = n_rise; v0 = n_rxv; m0 = mosi_q.size(); q0 = rx_q.size(); c0 = n_csr;
    push("C_accept0", 8'h97, 1'b0);
    wait_rises("C_first_byte", r0 + 8);
    n = 0;
    while (sck && n < 20) begin
      tick(1);
      n++;
    end
    tick(20);
    chk("C_wait_sck", sck, 0);
    chk("C_wait_ncs", n_cs, 0);
    chk("C_wait_ready", tx_ready, 1);
    chk("C_wait_rises", n_rise - r0, 8);
    chk("C_wait_mosi", mosi, 1);
    push("C_accept1", 8'h69, 1'b1);
    chk("C_resume_mosi", mosi, 0);
    cycles_to_rise("C_resume_rise", 2);
    wait_idle("C_idle");
    chk("C_rises", n_rise - r0, 16);
    chk("C_ncs_rises", n_csr - c0, 1);
    chk("C_rx0", rx_at(q0), 8'h97);
    chk("C_rx1", rx_at(q0 + 1), 8'h69);
    chk("C_mosi1", mosi_byte(m0 + 8), 8'h69);

    // Reset in the middle of 0x81, then a clean 0x55
    r0 = n_rise; v0 = n_rxv;
    push("D_accept", 8'h81, 1'b1);
    wait_rises("D_bit4", r0 + 4);
    tick(1);
    rst_n = 1'b0;
    tick(1);
    chk("D_rst_ncs", n_cs, 1);
    chk("D_rst_sck", sck, 0);
    chk("D_rst_busy", busy, 0);
    chk("D_rst_ready", tx_ready, 0);
    rst_n = 1'b1;
    tick(1);
    chk("D_ready_after_rst", tx_ready, 1);
    tick(20);
    chk("D_no_rxv", n_rxv - v0, 0);
    r0 = n_rise; v0 = n_rxv; m0 = mosi_q.size(); q0 = rx_q.size();
    push("D_accept55", 8'h55, 1'b1);
    wait_idle("D_idle");
    chk("D_rises", n_rise - r0, 8);
    chk("D_rxv_count", n_rxv - v0, 1);
    chk("D_rx", rx_at(q0), 8'h55);
    chk("D_mosi", mosi_byte(m0), 8'h55);

    // tx_valid held through HOLD/GAP: no accept until IDLE, chip select high long enough
    r0 = n_rise; v0 = n_rxv; q0 = rx_q.size();
    push("E_accept0", 8'h11, 1'b1);
    tx_data = 8'h22; tx_last = 1'b1; tx_valid = 1'b1;
    acc = 1'b0; n = 0; hi = 0; viol = 0;
    while (!acc && n < 300) begin
      acc = tx_ready;
      if (tx_ready && busy) viol++;
      if (n_cs) hi++;
      tick(1);
      n++;
    end
    tx_valid = 1'b0;
    chk("E_accept1", {31'b0, acc}, 1);
    chk("E_ready_while_busy", viol, 0);
    chk("E_ncs_high_min", {31'b0, hi >= CSI}, 1);
    chk("E_ncs_fall", n_cs, 0);
    wait_idle("E_idle");
    chk("E_rises", n_rise - r0, 16);
    chk("E_rxv_count", n_rxv - v0, 2);
    chk("E_rx0", rx_at(q0), 8'h11);
    chk("E_rx1", rx_at(q0 + 1), 8'h22);

    // Two-byte frame against the peripheral model preloaded with 0x5A
    miso_mode = 2;
    slave_load = 16'h005A;
    tick(2);
    v0 = n_rxv; q0 = rx_q.size();
    push("F_accept0", 8'hD2, 1'b0);
    push("F_accept1", 8'h4B, 1'b1);
    wait_idle("F_idle");
    chk("F_rxv_count", n_rxv - v0, 2);
    chk("F_rx0", rx_at(q0), 8'h00);
    chk("F_rx1", rx_at(q0 + 1), 8'h5A);
    chk("F_periph_rx", slave_rx, 16'hD24B);

    chk("sck_min_level", n_glitch, 0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule

// File: doc/spi_master.md
SPI_MASTER -- requirements
Module: spi_master

Interface
REQ-001 SHALL provide parameter HALF_PERIOD, default 4, clk cycles per sck half-period (legal range 1..255).
REQ-002 SHALL provide parameter CS_SETUP, default 2, clk cycles from n_cs fall to start of first sck low phase.
REQ-003 SHALL provide parameter CS_HOLD, default 2, clk cycles from last sck fall to n_cs rise.
REQ-004 SHALL provide parameter CS_IDLE, default 2, minimum clk cycles n_cs stays high between transactions.
REQ-005 SHALL have one clock; reset is synchronous and active-low: ports clk and rst_n.
REQ-006 clk  input  1  system clock; all logic on posedge.
REQ-007 rst_n  input  1  synchronous active-low reset.
REQ-008 sck  output  1  SPI clock, idle low (mode 0).
REQ-009 mosi  output  1  serial data out, MSB first.
REQ-010 miso  input  1  serial data in.
REQ-011 n_cs  output  1  chip select, active low.
REQ-012 tx_data  input  8  byte to send.
REQ-013 tx_valid  input  1  tx_data valid.
REQ-014 tx_last  input  1  accompanies tx_data; byte ends the transaction.
REQ-015 tx_ready  output  1  byte accepted on the cycle tx_valid && tx_ready.
REQ-016 rx_data  output  8  byte received.
REQ-017 rx_valid  output  1  one-cycle strobe, rx_data valid.
REQ-018 busy  output  1  high whenever state is not IDLE.

Function
REQ-019 States SHALL be IDLE, SETUP, LOW, HIGH, HOLD, GAP; all outputs registered.
REQ-020 IDLE: tx_ready=1, n_cs=1, sck=0; on accept, go to SETUP next cycle with n_cs=0 and mosi=tx_data[7].
REQ-021 SETUP SHALL last CS_SETUP cycles, then LOW.
REQ-022 LOW SHALL hold sck=0 for HALF_PERIOD cycles, then drive sck=1 and enter HIGH; miso SHALL be shifted into the rx register on that same clk edge.
REQ-023 HIGH SHALL hold sck=1 for HALF_PERIOD cycles, then drive sck=0; if bits remain, shift next bit onto mosi on that edge and go to LOW.
REQ-024 After the 8th rising edge, rx_data SHALL update and rx_valid SHALL pulse for exactly one cycle, on the cycle after that edge.
REQ-025 A one-entry holding buffer SHALL accept the next byte during a transfer; tx_ready = buffer empty AND no accepted byte carried tx_last.
REQ-026 At the 8th falling edge: current byte last -> HOLD; else buffer full -> load buffer, mosi=its bit 7, LOW (no sck gap); else stay in LOW with sck=0, n_cs=0, waiting indefinitely.
REQ-027 While waiting (REQ-026), a byte accepted on cycle N SHALL be loaded with mosi updated on cycle N+1; the full HALF_PERIOD low phase SHALL then be timed from N+1.
REQ-028 HOLD SHALL last CS_HOLD cycles with sck=0, then drive n_cs=1 and enter GAP.
REQ-029 GAP SHALL last CS_IDLE cycles with tx_ready=0, then IDLE.
REQ-030 tx_valid in HOLD/GAP SHALL be ignored (tx_ready=0); no byte is lost or duplicated.
REQ-031 Bit counter SHALL be 3 bits, wrapping 7->0 at the byte boundary; half-period counter SHALL be 8 bits.
REQ-032 sck SHALL never glitch: each sck level holds at least HALF_PERIOD cycles while n_cs=0.

Reset
REQ-033 While rst_n=0 at posedge clk: state=IDLE, n_cs=1, sck=0, mosi=0, tx_ready=0, rx_valid=0, rx_data=0, busy=0, buffer emptied, counters cleared.
REQ-034 Reset mid-transfer SHALL take effect on the next edge; the partial byte is discarded with no rx_valid; tx_ready=1 from the first cycle after rst_n=1.

Verification
REQ-035 HALF_PERIOD=2, CS_SETUP=2: send 0xA5 last, miso looped to mosi -> mosi bits 1,0,1,0,0,1,0,1; 8 sck pulses of period 4; first rise 4 cycles after n_cs fall; rx_data=0xA5, single rx_valid.
REQ-036 Send 0x3C then 0xC3 (last) with buffer prefilled -> 16 contiguous sck pulses, n_cs low throughout, rx_valid twice, miso=1 constant gives rx 0xFF, 0xFF.
REQ-037 Second byte presented 20 cycles after first byte ends -> sck held low, n_cs low; transfer resumes per REQ-027; no extra sck edges.
REQ-038 rst_n low during bit 4 of 0x81 -> next cycle n_cs=1, sck=0, no rx_valid; a following 0x55 transfers correctly.
REQ-039 tx_valid held high through HOLD/GAP with CS_IDLE=3 -> n_cs high for at least 3 cycles, next byte accepted only in IDLE.
REQ-040 Connect to the team's spi peripheral (same clk, HALF_PERIOD=4), peripheral loads 0x5A -> master rx_data=0x5A on the second byte of a 2-byte transaction; peripheral data_rx matches master tx bytes.
